mem_port_arbiter: RTL

Shares one memory request port (req/gnt, in-order rvalid) between NumInp requesters using round-robin arbitration with lock-in. Sits in front of the bank splitter, which fans one wide request out to parallel banks. Records the granted requester index per accepted transaction and routes each in-order response back to that requester.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_rr_lock_sel.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared helpers for the memory port arbiter slice: index width rules used by
// the selector and the outstanding-transaction index FIFO.
package mem_port_arbiter_pkg;

    // A single requester or a single FIFO slot still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Advance a circular pointer over n entries, wrapping at n-1.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_lock_sel.sv
// Round-robin requester selection starting at a rotating pointer, with an
// optional lock that holds the choice while a request waits for its grant.
module mem_port_arbiter_rr_lock_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NumInp   = 2,
    parameter bit          LockIn   = 1'b1,
    parameter int unsigned IdxWidth = idx_width(NumInp)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumInp-1:0]   req_i,
    input  logic                valid_i,
    input  logic                ready_i,
    output logic [IdxWidth-1:0] sel_o
);

    logic [IdxWidth-1:0] rr_ptr_reg;
    logic [IdxWidth-1:0] locked_idx_reg;
    logic                lock_reg;
    logic [IdxWidth-1:0] rr_sel;
    logic [IdxWidth-1:0] ptr_next;
    logic                found;
    int unsigned         cand;

    // Leading-one search beginning at the pointer, wrapping modulo NumInp.
    always_comb begin
        rr_sel = rr_ptr_reg;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned k = 0; k < NumInp; k++) begin
            cand = 32'(rr_ptr_reg) + k;
            if (cand >= NumInp) begin
                cand = cand - NumInp;
            end
            if (!found && req_i[cand[IdxWidth-1:0]]) begin
                found  = 1'b1;
                rr_sel = cand[IdxWidth-1:0];
            end
        end
    end

    assign sel_o    = (LockIn && lock_reg) ? locked_idx_reg : rr_sel;
    assign ptr_next = IdxWidth'(wrap_inc(32'(sel_o), NumInp));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_reg     <= '0;
            lock_reg       <= 1'b0;
            locked_idx_reg <= '0;
        end else if (valid_i && ready_i) begin
            rr_ptr_reg <= ptr_next;
            lock_reg   <= 1'b0;
        end else if (LockIn && valid_i) begin
            lock_reg       <= 1'b1;
            locked_idx_reg <= sel_o;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && LockIn && lock_reg) begin
            assert (req_i[locked_idx_reg])
                else $error("locked requester dropped its request before grant");
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one in-order req/gnt memory port among NumInp requesters and routes
// each response back to the requester recorded when its request was granted.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NumInp     = 2,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned WUserWidth = 1,
    parameter int unsigned RUserWidth = 1,
    parameter int unsigned MaxTrans   = 4,
    parameter bit          LockIn     = 1'b1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NumInp-1:0]                       inp_req_i,
    output logic [NumInp-1:0]                       inp_gnt_o,
    input  logic [NumInp-1:0][AddrWidth-1:0]        inp_addr_i,
    input  logic [NumInp-1:0][DataWidth-1:0]        inp_wdata_i,
    input  logic [NumInp-1:0][DataWidth/8-1:0]      inp_strb_i,
    input  logic [NumInp-1:0][WUserWidth-1:0]       inp_wuser_i,
    input  logic [NumInp-1:0]                       inp_we_i,
    output logic [NumInp-1:0]                       inp_rvalid_o,
    output logic [DataWidth-1:0]                    inp_rdata_o,
    output logic [RUserWidth-1:0]                   inp_ruser_o,
    output logic                                    oup_req_o,
    input  logic                                    oup_gnt_i,
    output logic [AddrWidth-1:0]                    oup_addr_o,
    output logic [DataWidth-1:0]                    oup_wdata_o,
    output logic [DataWidth/8-1:0]                  oup_strb_o,
    output logic [WUserWidth-1:0]                   oup_wuser_o,
    output logic                                    oup_we_o,
    input  logic                                    oup_rvalid_i,
    input  logic [DataWidth-1:0]                    oup_rdata_i,
    input  logic [RUserWidth-1:0]                   oup_ruser_i
);

    localparam int unsigned IdxWidth = idx_width(NumInp);
    localparam int unsigned PtrWidth = idx_width(MaxTrans);
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

    typedef logic [IdxWidth-1:0] idx_t;

    idx_t                sel;
    idx_t                head_idx;
    idx_t                fifo_mem [MaxTrans];
    logic [PtrWidth-1:0] wr_ptr_reg;
    logic [PtrWidth-1:0] rd_ptr_reg;
    logic [CntWidth-1:0] usage_reg;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    mem_port_arbiter_rr_lock_sel #(
        .NumInp   (NumInp),
        .LockIn   (LockIn),
        .IdxWidth (IdxWidth)
    ) u_sel (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (inp_req_i),
        .valid_i (oup_req_o),
        .ready_i (oup_gnt_i),
        .sel_o   (sel)
    );

    assign fifo_full  = (usage_reg == CntWidth'(MaxTrans));
    assign fifo_empty = (usage_reg == '0);

    // Full is judged on registered usage, so a pop never frees a slot early.
    assign oup_req_o   = (|inp_req_i) & ~fifo_full;
    assign oup_addr_o  = inp_addr_i[sel];
    assign oup_wdata_o = inp_wdata_i[sel];
    assign oup_strb_o  = inp_strb_i[sel];
    assign oup_wuser_o = inp_wuser_i[sel];
    assign oup_we_o    = inp_we_i[sel];

    assign push     = oup_req_o & oup_gnt_i;
    assign pop      = oup_rvalid_i & ~fifo_empty;
    assign head_idx = fifo_mem[rd_ptr_reg];

    assign inp_rdata_o = oup_rdata_i;
    assign inp_ruser_o = oup_ruser_i;

    for (genvar gi = 0; gi < NumInp; gi++) begin : g_route
        assign inp_gnt_o[gi]    = push & (sel == idx_t'(gi));
        assign inp_rvalid_o[gi] = pop & (head_idx == idx_t'(gi));
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            usage_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= PtrWidth'(wrap_inc(32'(wr_ptr_reg), MaxTrans));
            end
            if (pop) begin
                rd_ptr_reg <= PtrWidth'(wrap_inc(32'(rd_ptr_reg), MaxTrans));
            end
            if (push && !pop) begin
                usage_reg <= usage_reg + CntWidth'(1);
            end else if (pop && !push) begin
                usage_reg <= usage_reg - CntWidth'(1);
            end
        end
    end

`ifndef SYNTHESIS
    if (MaxTrans < 1) begin : g_bad_max_trans
        $error("MaxTrans must be at least 1");
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(inp_gnt_o))
                else $error("more than one grant in a cycle");
            assert (!(oup_rvalid_i && fifo_empty))
                else $error("response with no outstanding transaction");
        end
    end
`endif

endmodule
